fp_sqrt_seeded: RTL
===================

# fp_sqrt_seeded

Sequential unsigned fixed-point square root unit that consumes the leading-one location produced by the last-set-bit finder for the same operand. It uses that location to skip leading all-zero digit pairs of a restoring digit-by-digit square root, so small operands finish early. It sits directly downstream of the bit finder in the FPGA math path and feeds normalization and distance consumers with a Q(WIDTH-FP_B).FP_B result.

## Interface
- WIDTH, 16, operand and result width in bits.
- FP_B, 4, fractional bits of operand and result; 0 < FP_B < WIDTH.
- LOC_LAT, 2, cycles from `start` until the upstream `msb_loc`/`msb_valid` are valid; must be ≥ 1.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- operand  in  WIDTH  unsigned fixed-point radicand; sampled with an accepted `start`.
- msb_loc  in  6  index of the highest set bit of the integer part (operand >> FP_B).
- msb_valid  in  1  high when the integer part is nonzero.
- result  out  WIDTH  floor(sqrt(operand)) in the same Q format; held until the next accepted `start`.
- result_valid  out  1  one-cycle pulse when `result` is updated.
- busy  out  1  high in every state except IDLE.

## Operation
- Internal radicand R = operand << FP_B (WIDTH+FP_B bits). Integer sqrt of R equals sqrt(operand) with FP_B fraction bits.
- N = ceil((WIDTH+FP_B)/2) digit pairs. Pair index k covers R bits [2k+1:2k].
- States:
  - IDLE: `start` latches `operand`, clears the root and remainder, and goes to WAIT.
  - WAIT: lasts LOC_LAT cycles. On the last WAIT cycle it samples `msb_loc`/`msb_valid`, loads the start pair k0, and goes to ITER.
  - ITER: one pair per cycle, from k0 down to 0. Each cycle computes trial = {rem, pair} − {root, 2'b01}. If trial ≥ 0, rem = trial and root = {root,1}; otherwise rem = {rem, pair} and root = {root,0}. After pair 0 it goes to DONE.
  - DONE: `result` = root zero-extended to WIDTH, `result_valid` = 1, then returns to IDLE.
- Seed: k0 = floor((msb_loc + 2·FP_B)/2) if `msb_valid`, else FP_B−1.
  - If msb_loc > WIDTH−FP_B−1 (out of range), k0 = N−1.
  - k0 is always clamped to N−1.
- Pairs above k0 are zero by construction, so they are skipped without affecting the result.
- `start` while `busy` is ignored and does not disturb the operation in flight.
- `msb_loc`/`msb_valid` are ignored outside the sampling cycle.
- The upstream is not back-pressured; the upstream must not be restarted during a pending operation.

## Timing
- Reset: state = IDLE, `result` = 0, `result_valid` = 0, `busy` = 0, internal root and remainder = 0.
- Reset asserted in any state aborts the operation. No `result_valid` is produced for it, and `result` returns to 0.
- `start` accepted in cycle 0:
  - `busy` = 1 from cycle 1.
  - WAIT occupies cycles 1..LOC_LAT.
  - ITER occupies cycles LOC_LAT+1..LOC_LAT+k0+1.
  - `result_valid` = 1 in cycle LOC_LAT+k0+2.
  - `busy` = 0 from cycle LOC_LAT+k0+3.
- Latency range: LOC_LAT+2 (k0 = 0) to LOC_LAT+N+1.
- `start` in the DONE cycle is ignored. The earliest accepted back-to-back `start` is the cycle after DONE.

## Configuration
- `FP_SQRT_SEED_EN` defined: seeding from `msb_loc`/`msb_valid` as described; latency is data dependent.
- `FP_SQRT_SEED_EN` undefined:
  - k0 = N−1 always, and the msb inputs are unused.
  - WAIT still lasts LOC_LAT cycles, giving a fixed latency of LOC_LAT+N+1.
  - `result` is bit-identical to the seeded build.

## Structure
- Shared package `fp_math_pkg` holds:
  - the state enum (IDLE, WAIT, ITER, DONE);
  - the pair-count function N(WIDTH, FP_B);
  - the 6-bit location type shared with the bit finder.
- One natural sub-module, `sqrt_pair_step`: a combinational single-pair trial subtract/restore. It is instantiated once and reused each ITER cycle.
- Seed computation and the FSM stay in the top module.

## Test plan
All scenarios use WIDTH=16, FP_B=4, LOC_LAT=2 (N=10).
- operand 0x0040 (4.0), msb_loc=2, msb_valid=1 → k0=5; `result` 0x0020 (2.0); `result_valid` in cycle 9.
- operand 0x0004 (0.25), msb_valid=0 → k0=3; `result` 0x0008 (0.5) in cycle 7. Operand 0x0000 → `result` 0x0000 in cycle 7.
- operand 0xFFFF, msb_loc=11 → k0=9; `result` 0x03FF in cycle 13. Same operand with msb_loc=63 (out of range) → identical result and timing.
- `start` pulses at cycles 0 and 4 with operand 0x0190 (25.0), then 0x0010 → only the first is accepted; `result` 0x0050 (5.0), single `result_valid`.
- `rst` asserted in cycle 5 of an operation on 0x0190 → no `result_valid`; `result`=0 and `busy`=0 the next cycle. A new `start` on 0x0040 then completes normally with 0x0020.
- Build without `FP_SQRT_SEED_EN`, operand 0x0040 → `result` 0x0020 with `result_valid` in cycle 13.

Source files
------------

// File: rtl/fp_math_pkg.sv
// Shared math-path types: sqrt FSM states, the bit-finder location type and
// the digit-pair count helper.
package fp_math_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Leading-one index as produced by the last-set-bit finder.
  typedef logic [5:0] loc_t;

  function automatic int pair_count(input int width, input int fp_b);
    return (width + fp_b + 1) / 2;
  endfunction

endpackage

// File: rtl/sqrt_pair_step.sv
// One restoring square-root digit step: brings in the next radicand pair and
// trial-subtracts {root, 01} from the widened remainder.
module sqrt_pair_step #(
  parameter int QW   = 10,
  parameter int REMW = 12
) (
  input  logic [REMW-1:0] i_rem,
  input  logic [1:0]      i_pair,
  input  logic [QW-1:0]   i_root,
  output logic [REMW-1:0] o_rem,
  output logic [QW-1:0]   o_root
);

  logic [REMW+2:0] w_cat;
  logic [REMW+2:0] w_sub;
  logic            w_neg;
  logic [1:0]      w_unused_trial_hi;
  logic [REMW-1:0] w_trial_lo;

  assign w_cat = {1'b0, i_rem, i_pair};
  assign w_sub = (REMW+3)'({i_root, 2'b01});
  // The true remainder never exceeds 2*root, so the low REMW bits are exact.
  assign {w_neg, w_unused_trial_hi, w_trial_lo} = w_cat - w_sub;

  assign o_rem  = w_neg ? {i_rem[REMW-3:0], i_pair} : w_trial_lo;
  assign o_root = {i_root[QW-2:0], ~w_neg};

endmodule

// File: rtl/fp_sqrt_seeded.sv
// Sequential fixed-point square root seeded by the upstream leading-one index.
// Define FP_SQRT_SEED_EN to skip the leading zero pairs; otherwise latency is fixed.
module fp_sqrt_seeded
  import fp_math_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FP_B    = 4,
  parameter int LOC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [5:0]       msb_loc,
  input  logic             msb_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int N    = pair_count(WIDTH, FP_B);
  localparam int RW   = 2 * N;
  localparam int REMW = N + 2;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int LW   = (LOC_LAT > 1) ? $clog2(LOC_LAT) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_rad;
  logic [N-1:0]    r_root;
  logic [REMW-1:0] r_rem;
  logic [KW-1:0]   r_k;
  logic [LW-1:0]   r_wait;
  logic [WIDTH-1:0] r_result;
  logic [KW-1:0]   w_k0;
  logic [1:0]      w_pair;
  logic [N-1:0]    w_root_nxt;
  logic [REMW-1:0] w_rem_nxt;

`ifdef FP_SQRT_SEED_EN
  loc_t       w_loc;
  logic [6:0] w_sum;
  logic [6:0] w_half;

  assign w_loc  = msb_loc;
  assign w_sum  = {1'b0, w_loc} + 7'(2 * FP_B);
  assign w_half = w_sum >> 1;

  // Pairs above k0 are zero for this operand, so iteration starts there.
  always_comb begin
    w_k0 = KW'(N - 1);
    if (!msb_valid)
      w_k0 = KW'(FP_B - 1);
    else if (w_loc > 6'(WIDTH - FP_B - 1))
      w_k0 = KW'(N - 1);
    else if (w_half > 7'(N - 1))
      w_k0 = KW'(N - 1);
    else
      w_k0 = KW'(w_half);
  end
`else
  logic w_unused_msb;

  assign w_unused_msb = ^{msb_loc, msb_valid};
  assign w_k0         = KW'(N - 1);
`endif

  assign w_pair = r_rad[{r_k, 1'b0} +: 2];

  sqrt_pair_step #(
    .QW   (N),
    .REMW (REMW)
  ) u_step (
    .i_rem  (r_rem),
    .i_pair (w_pair),
    .i_root (r_root),
    .o_rem  (w_rem_nxt),
    .o_root (w_root_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = WAIT;
      WAIT: if (r_wait == '0) w_state_nxt = ITER;
      ITER: if (r_k == '0) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != IDLE);
    result_valid = (r_state == DONE);
    dbg_state    = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rad    <= '0;
      r_root   <= '0;
      r_rem    <= '0;
      r_k      <= '0;
      r_wait   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_rad  <= RW'({operand, {FP_B{1'b0}}});
          r_root <= '0;
          r_rem  <= '0;
          r_wait <= LW'(LOC_LAT - 1);
        end
        WAIT: begin
          if (r_wait == '0) r_k <= w_k0;
          else              r_wait <= r_wait - LW'(1);
        end
        ITER: begin
          r_root <= w_root_nxt;
          r_rem  <= w_rem_nxt;
          r_k    <= r_k - KW'(1);
          if (r_k == '0) r_result <= WIDTH'(w_root_nxt);
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
